atm_session_ctrl: RTL and testbench



---
 rtl/atm_session_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_atm_session_ctrl.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/atm_session_ctrl.sv
// atm_session_ctrl: one-customer ATM session sequencer with
// persistent balance, PIN lockout, idle timeout and saturating deposit.
module atm_session_ctrl #(
  parameter int          BAL_W       = 8,
  parameter int          PIN_W       = 4,
  parameter int unsigned PIN_CODE    = 4'hF,
  parameter int unsigned INIT_BAL    = 16,
  parameter int          PIN_TRIES   = 3,
  parameter int          TIMEOUT     = 20,
  parameter int          LOCK_CYCLES = 50
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_card,
  input  logic             i_lang_valid,
  input  logic [1:0]       i_lang,
  input  logic             i_pin_valid,
  input  logic [PIN_W-1:0] i_pin,
  input  logic             i_op_valid,
  input  logic [2:0]       i_op,
  input  logic             i_amt_valid,
  input  logic [BAL_W-1:0] i_amt,
  input  logic             i_conf,
  input  logic             i_cancel,
  output logic [3:0]       o_state,
  output logic [1:0]       o_lang,
  output logic [BAL_W-1:0] o_balance,
  output logic             o_pin_fail,
  output logic             o_locked,
  output logic             o_depConf,
  output logic             o_withConf,
  output logic             o_transferConf,
  output logic             o_balEnq,
  output logic             o_balNotEnough,
  output logic             o_sat,
  output logic             o_timeout
);

  localparam int TRY_W = $clog2(PIN_TRIES + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam int LCK_W = $clog2(LOCK_CYCLES + 1);

  localparam logic [PIN_W-1:0] PIN_V    = PIN_W'(PIN_CODE);
  localparam logic [BAL_W-1:0] INIT_V   = BAL_W'(INIT_BAL);
  localparam logic [TRY_W-1:0] TRY_MAX  = TRY_W'(PIN_TRIES);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [LCK_W-1:0] LCK_LAST = LCK_W'(LOCK_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_LANG     = 4'd1,
    S_PIN      = 4'd2,
    S_MENU     = 4'd3,
    S_AMOUNT   = 4'd4,
    S_CONFIRM  = 4'd5,
    S_BAL_SHOW = 4'd6,
    S_LOCKED   = 4'd7
  } state_t;

  localparam logic [2:0] OP_EXIT = 3'd0;
  localparam logic [2:0] OP_DEP  = 3'd1;
  localparam logic [2:0] OP_WITH = 3'd2;
  localparam logic [2:0] OP_ENQ  = 3'd3;
  localparam logic [2:0] OP_XFER = 3'd4;

  state_t             state;
  logic [TRY_W-1:0]   tries;
  logic [TRY_W-1:0]   tries_inc;
  logic [TMO_W-1:0]   tmo_cnt;
  logic [LCK_W-1:0]   lck_cnt;
  logic [2:0]         op_q;
  logic [BAL_W-1:0]   amt_q;
  logic [BAL_W:0]     dep_sum;
  logic               any_stb;

  assign o_state   = state;
  assign tries_inc = tries + 1'b1;
  assign dep_sum   = {1'b0, o_balance} + {1'b0, amt_q};
  assign any_stb   = i_card | i_lang_valid | i_pin_valid | i_op_valid |
                     i_amt_valid | i_conf | i_cancel;

  // Session FSM: state, counters, latched data and all registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      tries          <= '0;
      tmo_cnt        <= '0;
      lck_cnt        <= '0;
      op_q           <= '0;
      amt_q          <= '0;
      o_lang         <= '0;
      o_balance      <= INIT_V;
      o_pin_fail     <= 1'b0;
      o_locked       <= 1'b0;
      o_depConf      <= 1'b0;
      o_withConf     <= 1'b0;
      o_transferConf <= 1'b0;
      o_balEnq       <= 1'b0;
      o_balNotEnough <= 1'b0;
      o_sat          <= 1'b0;
      o_timeout      <= 1'b0;
    end else begin
      o_pin_fail     <= 1'b0;
      o_depConf      <= 1'b0;
      o_withConf     <= 1'b0;
      o_transferConf <= 1'b0;
      o_balNotEnough <= 1'b0;
      o_sat          <= 1'b0;
      o_timeout      <= 1'b0;

      if (state == S_LOCKED) begin
        // every input is ignored until the lock period expires
        if (lck_cnt == LCK_LAST) begin
          state    <= S_IDLE;
          lck_cnt  <= '0;
          tries    <= '0;
          o_locked <= 1'b0;
        end else begin
          lck_cnt <= lck_cnt + 1'b1;
        end
      end else if (state == S_IDLE) begin
        tmo_cnt <= '0;
        if (i_card) begin
          state <= S_LANG;
        end
      end else if (i_cancel) begin
        // cancel beats every other strobe and any pending timeout
        state    <= S_IDLE;
        tmo_cnt  <= '0;
        op_q     <= '0;
        amt_q    <= '0;
        o_balEnq <= 1'b0;
      end else if (!any_stb && tmo_cnt == TMO_LAST) begin
        state     <= S_IDLE;
        tmo_cnt   <= '0;
        op_q      <= '0;
        amt_q     <= '0;
        o_balEnq  <= 1'b0;
        o_timeout <= 1'b1;
      end else begin
        tmo_cnt <= any_stb ? '0 : tmo_cnt + 1'b1;
        unique case (state)
          S_LANG: begin
            if (i_lang_valid) begin
              o_lang <= i_lang;
              state  <= S_PIN;
            end
          end
          S_PIN: begin
            if (i_pin_valid) begin
              if (i_pin == PIN_V) begin
                tries <= '0;
                state <= S_MENU;
              end else begin
                tries      <= tries_inc;
                o_pin_fail <= 1'b1;
                if (tries_inc >= TRY_MAX) begin
                  state    <= S_LOCKED;
                  lck_cnt  <= '0;
                  o_locked <= 1'b1;
                end
              end
            end
          end
          S_MENU: begin
            if (i_op_valid) begin
              if (i_op == OP_EXIT) begin
                state <= S_IDLE;
              end else if (i_op == OP_DEP || i_op == OP_WITH ||
                           i_op == OP_XFER) begin
                op_q  <= i_op;
                state <= S_AMOUNT;
              end else if (i_op == OP_ENQ) begin
                state    <= S_BAL_SHOW;
                o_balEnq <= 1'b1;
              end
            end
          end
          S_AMOUNT: begin
            if (i_amt_valid && i_amt != '0) begin
              amt_q <= i_amt;
              if (op_q != OP_DEP && i_amt > o_balance) begin
                o_balNotEnough <= 1'b1;
                state          <= S_MENU;
              end else begin
                state <= S_CONFIRM;
              end
            end
          end
          S_CONFIRM: begin
            if (i_conf) begin
              state <= S_MENU;
              if (op_q == OP_DEP) begin
                o_depConf <= 1'b1;
                if (dep_sum[BAL_W]) begin
                  o_balance <= '1;
                  o_sat     <= 1'b1;
                end else begin
                  o_balance <= dep_sum[BAL_W-1:0];
                end
              end else if (op_q == OP_WITH) begin
                o_withConf <= 1'b1;
                o_balance  <= o_balance - amt_q;
              end else begin
                o_transferConf <= 1'b1;
                o_balance      <= o_balance - amt_q;
              end
            end
          end
          S_BAL_SHOW: begin
            if (i_conf) begin
              state    <= S_MENU;
              o_balEnq <= 1'b0;
            end
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_atm_session_ctrl.sv
// tb_atm_session_ctrl: directed scenario tasks plus a random
// strobe run with a balance-consistency scoreboard.
module tb_atm_session_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_card = 0, i_lang_valid = 0, i_pin_valid = 0;
  logic       i_op_valid = 0, i_amt_valid = 0, i_conf = 0, i_cancel = 0;
  logic [1:0] i_lang = 0;
  logic [3:0] i_pin = 0;
  logic [2:0] i_op = 0;
  logic [7:0] i_amt = 0;

  logic [3:0] o_state;
  logic [1:0] o_lang;
  logic [7:0] o_balance;
  logic o_pin_fail, o_locked, o_depConf, o_withConf, o_transferConf;
  logic o_balEnq, o_balNotEnough, o_sat, o_timeout;

  logic [3:0] s_state;
  logic [1:0] s_lang;
  logic [7:0] s_balance;
  logic s_pin_fail, s_locked, s_depConf, s_withConf, s_transferConf;
  logic s_balEnq, s_balNotEnough, s_sat, s_timeout;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  atm_session_ctrl dut (
    .clk(clk), .rst(rst), .i_card(i_card),
    .i_lang_valid(i_lang_valid), .i_lang(i_lang),
    .i_pin_valid(i_pin_valid), .i_pin(i_pin),
    .i_op_valid(i_op_valid), .i_op(i_op),
    .i_amt_valid(i_amt_valid), .i_amt(i_amt),
    .i_conf(i_conf), .i_cancel(i_cancel),
    .o_state(o_state), .o_lang(o_lang), .o_balance(o_balance),
    .o_pin_fail(o_pin_fail), .o_locked(o_locked),
    .o_depConf(o_depConf), .o_withConf(o_withConf),
    .o_transferConf(o_transferConf), .o_balEnq(o_balEnq),
    .o_balNotEnough(o_balNotEnough), .o_sat(o_sat),
    .o_timeout(o_timeout)
  );

  atm_session_ctrl #(.INIT_BAL(250)) dut_s (
    .clk(clk), .rst(rst), .i_card(i_card),
    .i_lang_valid(i_lang_valid), .i_lang(i_lang),
    .i_pin_valid(i_pin_valid), .i_pin(i_pin),
    .i_op_valid(i_op_valid), .i_op(i_op),
    .i_amt_valid(i_amt_valid), .i_amt(i_amt),
    .i_conf(i_conf), .i_cancel(i_cancel),
    .o_state(s_state), .o_lang(s_lang), .o_balance(s_balance),
    .o_pin_fail(s_pin_fail), .o_locked(s_locked),
    .o_depConf(s_depConf), .o_withConf(s_withConf),
    .o_transferConf(s_transferConf), .o_balEnq(s_balEnq),
    .o_balNotEnough(s_balNotEnough), .o_sat(s_sat),
    .o_timeout(s_timeout)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    i_card = 0; i_lang_valid = 0; i_pin_valid = 0; i_op_valid = 0;
    i_amt_valid = 0; i_conf = 0; i_cancel = 0;
  endtask

  task automatic do_reset();
    clear_in();
    rst = 1;
    step();
    rst = 0;
  endtask

  task automatic card();
    i_card = 1; step(); i_card = 0;
  endtask

  task automatic lang(input logic [1:0] v);
    i_lang = v; i_lang_valid = 1; step(); i_lang_valid = 0;
  endtask

  task automatic pin(input logic [3:0] v);
    i_pin = v; i_pin_valid = 1; step(); i_pin_valid = 0;
  endtask

  task automatic op(input logic [2:0] v);
    i_op = v; i_op_valid = 1; step(); i_op_valid = 0;
  endtask

  task automatic amt(input logic [7:0] v);
    i_amt = v; i_amt_valid = 1; step(); i_amt_valid = 0;
  endtask

  task automatic conf();
    i_conf = 1; step(); i_conf = 0;
  endtask

  task automatic cancel();
    i_cancel = 1; step(); i_cancel = 0;
  endtask

  task automatic to_menu();
    card(); lang(2'd0); pin(4'hF);
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if (o_state !== 4'd0) begin
      fails++; $display("FAIL reset_state got %0d want 0", o_state);
    end
    tests++;
    if (o_balance !== 8'd16) begin
      fails++; $display("FAIL reset_bal got %0d want 16", o_balance);
    end
    tests++;
    if ({o_lang, o_pin_fail, o_locked, o_depConf, o_withConf,
         o_transferConf, o_balEnq, o_balNotEnough, o_sat,
         o_timeout} !== 11'd0) begin
      fails++; $display("FAIL reset_outs got nonzero want 0");
    end
  endtask

  task automatic test_deposit();
    do_reset();
    card();
    tests++;
    if (o_state !== 4'd1) begin
      fails++; $display("FAIL dep_lang_state got %0d want 1", o_state);
    end
    lang(2'd1);
    tests++;
    if (o_state !== 4'd2 || o_lang !== 2'd1) begin
      fails++;
      $display("FAIL dep_pin_state got %0d/%0d want 2/1", o_state, o_lang);
    end
    pin(4'hF);
    tests++;
    if (o_state !== 4'd3 || o_pin_fail !== 1'b0) begin
      fails++; $display("FAIL dep_menu got %0d want 3", o_state);
    end
    op(3'd1);
    amt(8'd2);
    tests++;
    if (o_state !== 4'd5) begin
      fails++; $display("FAIL dep_confirm got %0d want 5", o_state);
    end
    conf();
    tests++;
    if (o_depConf !== 1'b1 || o_balance !== 8'd18 || o_state !== 4'd3) begin
      fails++;
      $display("FAIL dep_commit got conf=%0b bal=%0d st=%0d want 1/18/3",
               o_depConf, o_balance, o_state);
    end
    step();
    tests++;
    if (o_depConf !== 1'b0) begin
      fails++; $display("FAIL dep_pulse_width got 1 want 0");
    end
  endtask

  task automatic test_withdraw();
    op(3'd2);
    amt(8'd18);
    conf();
    tests++;
    if (o_withConf !== 1'b1 || o_balance !== 8'd0) begin
      fails++;
      $display("FAIL wd_exact got conf=%0b bal=%0d want 1/0",
               o_withConf, o_balance);
    end
    op(3'd2);
    amt(8'd0);
    tests++;
    if (o_state !== 4'd4) begin
      fails++; $display("FAIL wd_zero_amt got %0d want 4", o_state);
    end
    amt(8'd1);
    tests++;
    if (o_balNotEnough !== 1'b1 || o_balance !== 8'd0 ||
        o_state !== 4'd3) begin
      fails++;
      $display("FAIL wd_nofunds got ne=%0b bal=%0d st=%0d want 1/0/3",
               o_balNotEnough, o_balance, o_state);
    end
    op(3'd6);
    tests++;
    if (o_state !== 4'd3) begin
      fails++; $display("FAIL illegal_op got %0d want 3", o_state);
    end
    op(3'd3);
    tests++;
    if (o_state !== 4'd6 || o_balEnq !== 1'b1) begin
      fails++; $display("FAIL bal_show got %0d want 6", o_state);
    end
    conf();
    op(3'd0);
    tests++;
    if (o_state !== 4'd0 || o_balEnq !== 1'b0) begin
      fails++; $display("FAIL exit got %0d want 0", o_state);
    end
  endtask

  task automatic test_lockout();
    int pf;
    int cnt;
    do_reset();
    card(); lang(2'd0);
    pf = 0;
    pin(4'h0); pf += int'(o_pin_fail);
    pin(4'h1); pf += int'(o_pin_fail);
    tests++;
    if (o_state !== 4'd2) begin
      fails++; $display("FAIL lock_early got %0d want 2", o_state);
    end
    pin(4'h2); pf += int'(o_pin_fail);
    tests++;
    if (pf != 3 || o_state !== 4'd7) begin
      fails++;
      $display("FAIL lock_enter got fails=%0d st=%0d want 3/7", pf, o_state);
    end
    cnt = 0;
    i_card = 1; i_cancel = 1;
    for (int k = 0; k < 200 && o_locked; k++) begin
      cnt++;
      step();
    end
    clear_in();
    tests++;
    if (cnt != 50 || o_state !== 4'd0) begin
      fails++;
      $display("FAIL lock_len got %0d st=%0d want 50/0", cnt, o_state);
    end
    to_menu();
    tests++;
    if (o_state !== 4'd3) begin
      fails++; $display("FAIL lock_after got %0d want 3", o_state);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    to_menu(); op(3'd1); amt(8'd10); conf();
    tests++;
    if (s_sat !== 1'b1 || s_depConf !== 1'b1 || s_balance !== 8'd255) begin
      fails++;
      $display("FAIL sat got sat=%0b conf=%0b bal=%0d want 1/1/255",
               s_sat, s_depConf, s_balance);
    end
    tests++;
    if (o_balance !== 8'd26 || o_sat !== 1'b0) begin
      fails++; $display("FAIL nosat got %0d want 26", o_balance);
    end
    do_reset();
    to_menu(); op(3'd1); amt(8'd5); conf();
    tests++;
    if (s_sat !== 1'b0 || s_balance !== 8'd255) begin
      fails++;
      $display("FAIL sat_edge got sat=%0b bal=%0d want 0/255",
               s_sat, s_balance);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    to_menu();
    repeat (19) step();
    tests++;
    if (o_state !== 4'd3 || o_timeout !== 1'b0) begin
      fails++; $display("FAIL tmo_early got %0d want 3", o_state);
    end
    step();
    tests++;
    if (o_state !== 4'd0 || o_timeout !== 1'b1) begin
      fails++;
      $display("FAIL tmo got st=%0d p=%0b want 0/1", o_state, o_timeout);
    end
    step();
    tests++;
    if (o_timeout !== 1'b0) begin
      fails++; $display("FAIL tmo_width got 1 want 0");
    end
    to_menu();
    repeat (19) step();
    cancel();
    tests++;
    if (o_state !== 4'd0 || o_timeout !== 1'b0) begin
      fails++;
      $display("FAIL tmo_cancel got st=%0d p=%0b want 0/0",
               o_state, o_timeout);
    end
  endtask

  task automatic test_cancel();
    do_reset();
    to_menu(); op(3'd1); amt(8'd5);
    i_conf = 1; i_cancel = 1; step(); clear_in();
    tests++;
    if (o_state !== 4'd0 || o_depConf !== 1'b0 || o_balance !== 8'd16) begin
      fails++;
      $display("FAIL cancel got st=%0d conf=%0b bal=%0d want 0/0/16",
               o_state, o_depConf, o_balance);
    end
    card(); lang(2'd0); pin(4'h3); cancel();
    card(); lang(2'd0); pin(4'h3); pin(4'h4);
    tests++;
    if (o_state !== 4'd7) begin
      fails++; $display("FAIL try_persist got %0d want 7", o_state);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    to_menu(); op(3'd1); amt(8'd2); conf();
    op(3'd1); amt(8'd3);
    #2 rst = 1;
    #1;
    tests++;
    if (o_state !== 4'd0 || o_balance !== 8'd16) begin
      fails++;
      $display("FAIL async_rst got st=%0d bal=%0d want 0/16",
               o_state, o_balance);
    end
    step();
    rst = 0;
  endtask

  task automatic test_random();
    logic [7:0] prev;
    logic ok;
    do_reset();
    prev = o_balance;
    for (int n = 0; n < 10000; n++) begin
      i_card       = ($urandom_range(0, 99) < 30);
      i_lang_valid = ($urandom_range(0, 99) < 30);
      i_lang       = 2'($urandom_range(0, 3));
      i_pin_valid  = ($urandom_range(0, 99) < 30);
      i_pin        = ($urandom_range(0, 4) == 0) ?
                     4'($urandom_range(0, 15)) : 4'hF;
      i_op_valid   = ($urandom_range(0, 99) < 30);
      i_op         = 3'($urandom_range(0, 7));
      i_amt_valid  = ($urandom_range(0, 99) < 30);
      i_amt        = 8'($urandom_range(0, 40));
      i_conf       = ($urandom_range(0, 99) < 30);
      i_cancel     = ($urandom_range(0, 99) < 2);
      step();
      ok = 1'b1;
      if (o_depConf) ok = (o_balance >= prev) &&
                          (!o_sat || o_balance == 8'hFF);
      else if (o_withConf || o_transferConf) ok = (o_balance <= prev);
      else ok = (o_balance == prev) && !o_sat;
      if (o_state > 4'd7) ok = 1'b0;
      tests++;
      if (!ok) begin
        fails++;
        $display("FAIL rand_bal cycle %0d got %0d prev %0d st=%0d",
                 n, o_balance, prev, o_state);
      end
      prev = o_balance;
    end
    clear_in();
  endtask

  initial begin
    test_reset();
    test_deposit();
    test_withdraw();
    test_lockout();
    test_saturation();
    test_timeout();
    test_cancel();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
